latency_probe: RTL and testbench
================================

// Module: latency_probe
// PURPOSE
//  Active measurement end for a pipelined data path such as a delay chain: drives a
//  known marker word into the path input and watches the path output, counting cycles.
//  Reports the measured latency in clock cycles, or a timeout if no marker returns.
//  Used in bring-up benches and BIST to check delay-line length against its configuration.
// PARAMETERS
//  DW       8      data width of the probed path
//  MAX_LAT  64     largest latency measurable; a longer path yields timeout
//  PATTERN  8'hA5  marker word (DW bits); the background word is ~PATTERN
//  CW       localparam = $clog2(MAX_LAT+1), latency counter width
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  start      in   1    request a measurement; sampled in IDLE only
//  probe_en   out  1    enable to path under test (the en of the chain)
//  probe_out  out  DW   registered word driven into the path input
//  probe_in   in   DW   path output
//  busy       out  1    high in FLUSH/LAUNCH/WAIT
//  done       out  1    1-cycle pulse: marker returned, latency valid
//  timeout    out  1    1-cycle pulse: no marker within MAX_LAT cycles
//  latency    out  CW   measured cycles, held until next start
//  lat_valid  out  1    high after a successful measurement, cleared by start/timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; probe_en=0, probe_out=~PATTERN, busy=done=timeout=0,
//   latency=0, lat_valid=0. A mid-measurement reset abandons the run with no pulse.
//  IDLE: probe_en=0 (path frozen), probe_out=~PATTERN. start=1 -> FLUSH, lat_valid<=0,
//   cnt<=0. start while busy is ignored, with no queuing.
//  FLUSH: probe_en=1, probe_out=~PATTERN for exactly MAX_LAT cycles (cnt 0..MAX_LAT-1),
//   then -> LAUNCH. probe_in is ignored; a stray PATTERN here is not a match.
//  LAUNCH: probe_out=PATTERN for exactly one cycle (cycle index k=0); cnt=0.
//  WAIT: probe_out=~PATTERN, probe_en=1. Compare in every cycle k, including LAUNCH:
//   probe_in==PATTERN -> latency<=k, lat_valid<=1, done pulses next cycle, -> IDLE.
//   Else if k==MAX_LAT -> timeout pulses next cycle, latency unchanged, -> IDLE.
//   Else k++.
//   The first match wins; later copies are ignored.
//  Latency definition: a path of N register stages with en held high yields latency=N.
//   A combinational path yields latency=0.
//  probe_out is a register with no combinational path to probe_in.
//   probe_en drops in the same cycle that done or timeout pulses.
//  done and timeout are mutually exclusive and are never both asserted.
//  Priority within a cycle: a match beats timeout when k==MAX_LAT.
// STRUCTURE
//  Package delay_pkg: typedef enum logic [2:0] {IDLE,FLUSH,LAUNCH,WAIT} probe_state_t;
//   default PATTERN constant PROBE_PATTERN_DEF.
//  Single module; no sub-module is warranted. One state register, one CW-bit counter
//   shared by FLUSH and WAIT, and registered outputs.
// TESTING
//  Bench: latency_probe (MAX_LAT=16) closes a loop around DelayChain.
//  1 DelayChain DW=8 LEN=5, start 1 cycle -> busy 16+1+5 cycles, done pulse,
//    latency=5, lat_valid=1.
//  2 LEN=1 -> latency=1. Wire loopback probe_in=probe_out -> latency=0.
//  3 probe_in tied 8'h00 -> timeout pulse after compare cycle k=16, lat_valid=0,
//    latency keeps its prior value, done never asserts.
//  4 start pulsed again during WAIT of a LEN=5 run -> ignored; single done, latency=5.
//  5 rst_n low during WAIT -> all outputs at reset values next sample, no pulse;
//    then start -> latency=5.
//  6 Chain pre-loaded with 8'hA5 garbage before start -> the flush clears it;
//    latency=5, not 0.

Source files
------------

// File: rtl/delay_pkg.sv
// Package shared by the latency probe and anything that talks to it.
// Holds the probe FSM state encoding and the default marker word.
package delay_pkg;

  // Probe FSM states: idle, flush the path, launch the marker, wait for it.
  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    LAUNCH,
    WAIT
  } probe_state_t;

  // Default marker word; the background word driven otherwise is its inverse.
  localparam logic [7:0] PROBE_PATTERN_DEF = 8'hA5;

endpackage

// File: rtl/latency_probe.sv
// latency_probe: active measurement end for a pipelined data path.
// Drives a background word (~PATTERN) into the path for MAX_LAT cycles to
// flush it, launches a single PATTERN word, then counts cycles until the
// marker shows up on the path output. Reports latency or a timeout.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request a measurement (only honoured in IDLE)
//   probe_en   enable for the path under test, high while busy
//   probe_out  registered word driven into the path input
//   probe_in   path output being watched
//   busy       high in FLUSH/LAUNCH/WAIT
//   done       one-cycle pulse, marker returned and latency valid
//   timeout    one-cycle pulse, marker did not return within MAX_LAT cycles
//   latency    measured latency in cycles, held until the next start
//   lat_valid  high after a successful measurement
module latency_probe
  import delay_pkg::*;
#(
  parameter int             DW      = 8,
  parameter int             MAX_LAT = 64,
  parameter logic [DW-1:0]  PATTERN = DW'(PROBE_PATTERN_DEF),
  localparam int            CW      = $clog2(MAX_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          probe_en,
  output logic [DW-1:0] probe_out,
  input  logic [DW-1:0] probe_in,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] latency,
  output logic          lat_valid
);

  localparam logic [CW-1:0] FLUSH_LAST = CW'(MAX_LAT - 1);
  localparam logic [CW-1:0] K_LAST     = CW'(MAX_LAT);

  probe_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] latency_q, latency_d;
  logic          lat_valid_q, lat_valid_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          probe_en_q, probe_en_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] probe_out_q, probe_out_d;
  logic          match;

  assign match = (probe_in == PATTERN);

  // Next-state logic. The counter is shared: it counts flush cycles in
  // FLUSH and the cycle index k in LAUNCH/WAIT. LAUNCH is compare cycle
  // k=0 so a combinational loopback measures zero. A match is checked
  // before the timeout so a marker arriving exactly at k=MAX_LAT wins.
  // Outputs are computed from the next state so that the registered
  // outputs line up with the registered state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latency_d   = latency_q;
    lat_valid_d = lat_valid_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = FLUSH;
          cnt_d       = '0;
          lat_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = LAUNCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LAUNCH, WAIT: begin
        if (match) begin
          state_d     = IDLE;
          latency_d   = cnt_q;
          lat_valid_d = 1'b1;
          done_d      = 1'b1;
        end else if (cnt_q == K_LAST) begin
          state_d     = IDLE;
          lat_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    probe_en_d  = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    probe_out_d = (state_d == LAUNCH) ? PATTERN : ~PATTERN;
  end

  // State, counter and all outputs are registered; a reset abandons any
  // run in progress without producing a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      latency_q   <= '0;
      lat_valid_q <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      probe_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      probe_out_q <= ~PATTERN;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latency_q   <= latency_d;
      lat_valid_q <= lat_valid_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      probe_en_q  <= probe_en_d;
      busy_q      <= busy_d;
      probe_out_q <= probe_out_d;
    end
  end

  assign probe_en  = probe_en_q;
  assign probe_out = probe_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign latency   = latency_q;
  assign lat_valid = lat_valid_q;

endmodule

// File: tb/tb_latency_probe.sv
// Testbench for latency_probe (MAX_LAT=16). Closes the loop through a
// behavioural delay chain of selectable length (0 = wire loopback), with
// an option to tie the path output to zero and to preload the chain.
module tb_latency_probe;

  localparam int DW      = 8;
  localparam int MAX_LAT = 16;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [DW-1:0] PAT = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          probeEn;
  logic [DW-1:0] probeOut;
  logic [DW-1:0] probeIn;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] latency;
  logic          latValid;

  int            chainLen;
  logic          tiedZero;
  logic          preload;
  logic [DW-1:0] chainQ [0:15];

  int total;
  int bad;

  typedef struct {
    string name;
    int    len;
    logic  tied;
    int    expLat;
    logic  expDone;
    int    expBusy;
    logic  expValid;
  } vec_t;

  vec_t vecs [5];

  int   obsBusy;
  int   obsMarker;
  int   obsDone;
  int   obsTimeout;
  int   obsLat;
  int   obsValid;
  int   obsEn;
  int   obsValidBusy;
  int   obsPulseNext;

  latency_probe #(
    .DW      (DW),
    .MAX_LAT (MAX_LAT),
    .PATTERN (PAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .probe_en  (probeEn),
    .probe_out (probeOut),
    .probe_in  (probeIn),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .latency   (latency),
    .lat_valid (latValid)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Path under test: a register chain advancing only when probe_en is high.
  // preload fills every stage with the marker to emulate stale garbage.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) chainQ[i] <= PAT;
    end else if (probeEn) begin
      chainQ[0] <= probeOut;
      for (int i = 1; i < 16; i++) chainQ[i] <= chainQ[i-1];
    end
  end

  // Path output selection: tied low, wire loopback, or chain stage LEN.
  always_comb begin
    probeIn = 8'h00;
    if (tiedZero) probeIn = 8'h00;
    else if (chainLen == 0) probeIn = probeOut;
    else probeIn = chainQ[chainLen-1];
  end

  // Safety net in case something hangs outside the bounded loops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got hang expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Runs one measurement with the given path setup and records what was seen.
  task automatic applyStimulus(input int len, input logic tied);
    @(negedge clk);
    chainLen = len;
    tiedZero = tied;
    start    = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    obsValidBusy = int'(latValid);
    obsBusy      = 0;
    obsMarker    = 0;
    while (busy && obsBusy < 200) begin
      obsBusy++;
      if (probeOut == PAT) obsMarker++;
      @(negedge clk);
    end
    obsDone    = int'(done);
    obsTimeout = int'(timeout);
    obsLat     = int'(latency);
    obsValid   = int'(latValid);
    obsEn      = int'(probeEn);
    @(negedge clk);
    obsPulseNext = int'(done) + int'(timeout);
  endtask

  initial begin
    int doneCount;
    int pulseCount;
    int busyRises;
    logic busyPrev;

    total    = 0;
    bad      = 0;
    start    = 1'b0;
    preload  = 1'b0;
    chainLen = 5;
    tiedZero = 1'b0;
    rst_n    = 1'b0;

    vecs[0] = '{"len5",     5,  1'b0, 5,  1'b1, 22, 1'b1};
    vecs[1] = '{"len1",     1,  1'b0, 1,  1'b1, 18, 1'b1};
    vecs[2] = '{"tied0",    0,  1'b1, 1,  1'b0, 33, 1'b0};
    vecs[3] = '{"len16",    16, 1'b0, 16, 1'b1, 33, 1'b1};
    vecs[4] = '{"loopback", 0,  1'b0, 0,  1'b1, 17, 1'b1};

    // Reset values while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_probe_en",  int'(probeEn),  0);
    checkOutput("rst_probe_out", int'(probeOut), 'h5A);
    checkOutput("rst_busy",      int'(busy),     0);
    checkOutput("rst_done",      int'(done),     0);
    checkOutput("rst_timeout",   int'(timeout),  0);
    checkOutput("rst_latency",   int'(latency),  0);
    checkOutput("rst_lat_valid", int'(latValid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] table-driven measurements");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].len, vecs[v].tied);
      checkOutput({vecs[v].name, "_busy_cycles"},  obsBusy,    vecs[v].expBusy);
      checkOutput({vecs[v].name, "_marker_cycles"}, obsMarker, 1);
      checkOutput({vecs[v].name, "_valid_cleared"}, obsValidBusy, 0);
      checkOutput({vecs[v].name, "_done"},    obsDone,    int'(vecs[v].expDone));
      checkOutput({vecs[v].name, "_timeout"}, obsTimeout, int'(!vecs[v].expDone));
      checkOutput({vecs[v].name, "_latency"}, obsLat,     vecs[v].expLat);
      checkOutput({vecs[v].name, "_lat_valid"}, obsValid, int'(vecs[v].expValid));
      checkOutput({vecs[v].name, "_en_dropped"}, obsEn,   0);
      checkOutput({vecs[v].name, "_pulse_one_cycle"}, obsPulseNext, 0);
    end

    // start pulsed during WAIT of a LEN=5 run must be ignored.
    $display("[TB] start during WAIT");
    @(negedge clk);
    chainLen  = 5;
    tiedZero  = 1'b0;
    start     = 1'b1;
    doneCount = 0;
    busyRises = 0;
    busyPrev  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy && !busyPrev) busyRises++;
      busyPrev = busy;
      if (done) doneCount++;
      if (i == 0)  start = 1'b0;
      if (i == 19) start = 1'b1;
      if (i == 20) start = 1'b0;
    end
    checkOutput("restart_done_count", doneCount,     1);
    checkOutput("restart_busy_rises", busyRises,     1);
    checkOutput("restart_latency",    int'(latency), 5);

    // Reset asserted during WAIT abandons the run silently.
    $display("[TB] reset during WAIT");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (18) @(negedge clk);
    checkOutput("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_probe_en",  int'(probeEn),  0);
    checkOutput("midrst_probe_out", int'(probeOut), 'h5A);
    checkOutput("midrst_busy",      int'(busy),     0);
    checkOutput("midrst_latency",   int'(latency),  0);
    checkOutput("midrst_lat_valid", int'(latValid), 0);
    pulseCount = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 2) rst_n = 1'b1;
      @(negedge clk);
      pulseCount += int'(done) + int'(timeout) + int'(busy);
    end
    checkOutput("midrst_no_pulse", pulseCount, 0);
    applyStimulus(5, 1'b0);
    checkOutput("postrst_done",    obsDone, 1);
    checkOutput("postrst_latency", obsLat,  5);

    // Chain pre-loaded with marker garbage: flush must clear it.
    $display("[TB] preloaded chain");
    @(negedge clk);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    applyStimulus(5, 1'b0);
    checkOutput("preload_done",      obsDone,  1);
    checkOutput("preload_latency",   obsLat,   5);
    checkOutput("preload_lat_valid", obsValid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
